key_source_arbiter: RTL and testbench
=====================================

KEY_SOURCE_ARBITER -- requirements
Module: key_source_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of key source channels (1..8).
REQ-002 SHALL have parameter DW, default 8, meaning key code width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, meaning per-channel FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter MODE, default 1, meaning 0 = fixed priority (channel 0 highest), 1 = round-robin.
REQ-005 SHALL have port clk_100  input  1  system clock; single clock domain for the whole block.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port src_dat  input  NCH*DW  per-channel key code; channel i occupies bits [i*DW +: DW].
REQ-008 SHALL have port src_dv  input  NCH  per-channel valid level; may stay high for many cycles.
REQ-009 SHALL have port out_tick  input  1  one-cycle output pacing strobe, already in clk_100 domain.
REQ-010 SHALL have port clr_ovf  input  1  synchronous clear of all overflow flags.
REQ-011 SHALL have port key_out  output  DW  last dispatched key code, held between dispatches.
REQ-012 SHALL have port key_wen  output  1  one-cycle write-enable pulse per dispatched key.
REQ-013 SHALL have port key_src  output  max(1,clog2(NCH))  channel index of key_out.
REQ-014 SHALL have port ovf  output  NCH  sticky per-channel overflow flag.

Function
REQ-015 SHALL capture a key on channel i only on a src_dv[i] rising edge (src_dv[i]=1 this cycle, 0 previous cycle); held-high valid SHALL NOT cause further captures.
REQ-016 SHALL write src_dat slice i into FIFO i at the end of the edge cycle; no capture needed for a channel whose valid never falls.
REQ-017 SHALL, on an edge with FIFO i full and not popped that cycle, drop the key and set ovf[i]; FIFO contents SHALL be unchanged.
REQ-018 SHALL, on a cycle with out_tick=1 and at least one non-empty FIFO (occupancy as registered at start of cycle), pop exactly one entry.
REQ-019 SHALL select the popped channel in MODE 0 as lowest-index non-empty FIFO.
REQ-020 SHALL select in MODE 1 the first non-empty FIFO at or after rr_ptr (wrapping NCH-1 -> 0), then set rr_ptr to winner+1 modulo NCH.
REQ-021 SHALL, in the cycle after a pop, drive key_wen=1, key_out=popped data, key_src=winner; key_wen SHALL be 0 in all other cycles.
REQ-022 SHALL ignore out_tick when all FIFOs are empty: no pop, no key_wen, rr_ptr unchanged.
REQ-023 SHALL on simultaneous push and pop of a full FIFO i accept the push (no overflow).
REQ-024 SHALL on simultaneous push into an empty FIFO and out_tick not pop that entry that cycle; it is eligible from the next tick.
REQ-025 SHALL give minimum latency: edge in cycle n, out_tick in cycle n+1, key_wen in cycle n+2.
REQ-026 SHALL clear all ovf bits when clr_ovf=1; a same-cycle new overflow SHALL take precedence and set its bit.
REQ-027 SHALL preserve FIFO order per channel; inter-channel order follows REQ-019/020 only.

Reset
REQ-028 SHALL on rst_n=0 immediately force key_out=0, key_wen=0, key_src=0, ovf=0, all FIFOs empty, rr_ptr=0.
REQ-029 SHALL reset the src_dv history registers to all-ones so a valid held high through reset release is not captured.
REQ-030 SHALL discard any queued keys and any in-flight pop when reset asserts mid-operation.

Structure
REQ-031 SHALL place MODE_PRIORITY=0, MODE_RR=1 and the channel-index width function in shared package key_arb_pkg.
REQ-032 SHALL instantiate NCH copies of one sub-module key_fifo (synchronous, DW x DEPTH, push/pop/full/empty, same clock and reset).

Verification
REQ-033 NCH=2, MODE=1: ch0 edge 0x1C, ch1 edge 0x32 same cycle, ticks every 4 cycles -> key_wen twice, 0x1C/src0 then 0x32/src1.
REQ-034 ch0 src_dv held high 20 cycles with one edge, 3 ticks -> exactly one key_wen.
REQ-035 DEPTH=4, five ch0 edges with no ticks -> ovf[0]=1, ticks then yield first four codes in order; clr_ovf -> ovf=0.
REQ-036 MODE=0, both FIFOs holding 2 keys -> four ticks yield ch0, ch0, ch1, ch1.
REQ-037 Full FIFO with push and tick same cycle -> no ovf, occupancy unchanged, new code emitted last.
REQ-038 rst_n low while 3 keys queued and src_dv high -> outputs 0 asynchronously; after release, ticks produce no key_wen.

Source files
------------

// File: rtl/key_arb_pkg.sv
// Shared constants and helpers for the key source arbiter.
package key_arb_pkg;
  localparam int MODE_PRIORITY = 0;
  localparam int MODE_RR       = 1;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_fifo.sv
// Per-channel key FIFO; head data is visible combinationally on dout.
module key_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk_100,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [AW-1:0]            wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]              cnt_q, cnt_d;
  logic                     do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_q];

  // Push while full is legal only when the same cycle frees a slot.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/key_source_arbiter.sv
// Captures key codes on valid rising edges into per-channel FIFOs and
// dispatches one key per out_tick, by fixed priority or round-robin.
module key_source_arbiter
  import key_arb_pkg::*;
#(
  parameter  int NCH   = 2,
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  parameter  int MODE  = 1,
  localparam int IW    = idx_w(NCH)
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] src_dat,
  input  logic [NCH-1:0]    src_dv,
  input  logic              out_tick,
  input  logic              clr_ovf,
  output logic [DW-1:0]     key_out,
  output logic              key_wen,
  output logic [IW-1:0]     key_src,
  output logic [NCH-1:0]    ovf
);
  logic [NCH-1:0]         dv_q, dv_d;
  logic [NCH-1:0]         ovf_q, ovf_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic [DW-1:0]          key_out_q, key_out_d;
  logic                   key_wen_q, key_wen_d;
  logic [IW-1:0]          key_src_q, key_src_d;

  logic [NCH-1:0]         dv_rise, push, pop, fifo_full, fifo_empty;
  logic [NCH-1:0][DW-1:0] fifo_dout;
  logic [IW-1:0]          win;
  logic                   any_ne, do_pop;
  int                     idx;

  assign dv_rise = src_dv & ~dv_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    key_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk_100 (clk_100),
      .rst_n   (rst_n),
      .push    (push[i]),
      .pop     (pop[i]),
      .din     (src_dat[i*DW +: DW]),
      .dout    (fifo_dout[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );
  end

  always_comb begin
    win    = '0;
    any_ne = 1'b0;
    idx    = 0;
    // Scan from the far end so the nearest non-empty candidate wins last.
    for (int k = NCH-1; k >= 0; k--) begin
      idx = (MODE == MODE_RR) ? (int'(rr_q) + k) % NCH : k;
      if (!fifo_empty[idx]) begin
        win    = IW'(idx);
        any_ne = 1'b1;
      end
    end
    do_pop = out_tick & any_ne;

    pop = '0;
    if (do_pop) pop[win] = 1'b1;
    push  = dv_rise & (~fifo_full | pop);
    ovf_d = (clr_ovf ? '0 : ovf_q) | (dv_rise & fifo_full & ~pop);

    rr_d = rr_q;
    if (do_pop && MODE == MODE_RR)
      rr_d = (int'(win) + 1 == NCH) ? '0 : win + 1'b1;

    key_wen_d = do_pop;
    key_out_d = do_pop ? fifo_dout[win] : key_out_q;
    key_src_d = do_pop ? win : key_src_q;
    dv_d      = src_dv;
  end

  // Valid history resets high so a level held across reset is not an edge.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      dv_q      <= '1;
      ovf_q     <= '0;
      rr_q      <= '0;
      key_out_q <= '0;
      key_wen_q <= 1'b0;
      key_src_q <= '0;
    end else begin
      dv_q      <= dv_d;
      ovf_q     <= ovf_d;
      rr_q      <= rr_d;
      key_out_q <= key_out_d;
      key_wen_q <= key_wen_d;
      key_src_q <= key_src_d;
    end
  end

  assign key_out = key_out_q;
  assign key_wen = key_wen_q;
  assign key_src = key_src_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_key_source_arbiter.sv
// Bench: one fixed-priority and one round-robin instance share stimulus;
// directed scenarios plus a random run against a queue-level model.
module tb_key_source_arbiter;
  logic        clk_100 = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] src_dat = '0;
  logic [1:0]  src_dv  = '0;
  logic        out_tick = 1'b0;
  logic        clr_ovf  = 1'b0;

  // index 0 = fixed priority instance, index 1 = round-robin instance
  logic [7:0] ko [2];
  logic       kw [2];
  logic [0:0] ks [2];
  logic [1:0] ov [2];

  int nvec = 0;
  int nerr = 0;

  always #5 clk_100 = ~clk_100;

  key_source_arbiter #(.NCH(2), .DW(8), .DEPTH(4), .MODE(0)) u_pri (
    .clk_100(clk_100), .rst_n(rst_n), .src_dat(src_dat), .src_dv(src_dv),
    .out_tick(out_tick), .clr_ovf(clr_ovf),
    .key_out(ko[0]), .key_wen(kw[0]), .key_src(ks[0]), .ovf(ov[0]));

  key_source_arbiter #(.NCH(2), .DW(8), .DEPTH(4), .MODE(1)) u_rr (
    .clk_100(clk_100), .rst_n(rst_n), .src_dat(src_dat), .src_dv(src_dv),
    .out_tick(out_tick), .clr_ovf(clr_ovf),
    .key_out(ko[1]), .key_wen(kw[1]), .key_src(ks[1]), .ovf(ov[1]));

  // dispatched keys as {src, code}
  logic [8:0] got0[$];
  logic [8:0] got1[$];
  always @(negedge clk_100) begin
    if (kw[0]) got0.push_back({ks[0], ko[0]});
    if (kw[1]) got1.push_back({ks[1], ko[1]});
  end

  // Reference model: per-mode, per-channel queues held as arrays.
  int         mn   [2][2];
  logic [7:0] ment [2][2][4];
  int         mrr  [2];
  logic [1:0] mprev;
  logic [1:0] movf [2];
  logic       ewen [2];
  logic [7:0] eout [2];
  logic       esrc [2];

  task automatic model_reset();
    mprev = 2'b11;
    for (int m = 0; m < 2; m++) begin
      mn[m][0] = 0; mn[m][1] = 0; mrr[m] = 0; movf[m] = 2'b00;
      ewen[m] = 1'b0; eout[m] = 8'h00; esrc[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [1:0] rise;
    int w, cc;
    int sn[2];
    rise  = src_dv & ~mprev;
    mprev = src_dv;
    for (int m = 0; m < 2; m++) begin
      w = -1;
      sn[0] = mn[m][0]; sn[1] = mn[m][1];
      if (out_tick)
        for (int k = 0; k < 2; k++) begin
          cc = (m == 1) ? (mrr[m] + k) % 2 : k;
          if (w < 0 && sn[cc] > 0) w = cc;
        end
      ewen[m] = (w >= 0);
      if (w >= 0) begin
        eout[m] = ment[m][w][0];
        esrc[m] = (w == 1);
        for (int j = 0; j < 3; j++) ment[m][w][j] = ment[m][w][j+1];
        mn[m][w]--;
        mrr[m] = (w + 1) % 2;
      end
      if (clr_ovf) movf[m] = 2'b00;
      for (int c = 0; c < 2; c++)
        if (rise[c]) begin
          if (sn[c] == 4 && w != c) movf[m][c] = 1'b1;
          else begin
            ment[m][c][mn[m][c]] = src_dat[c*8 +: 8];
            mn[m][c]++;
          end
        end
    end
  endtask

  task automatic cyc(input logic [1:0] dv, input logic [7:0] d0, input logic [7:0] d1,
                     input logic tk, input logic clr);
    src_dv = dv; src_dat = {d1, d0}; out_tick = tk; clr_ovf = clr;
    @(posedge clk_100);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_100);
    #1 rst_n = 1'b1;
    got0.delete();
    got1.delete();
  endtask

  task automatic test_reset();
    src_dv = 2'b11; out_tick = 1'b1;
    rst_n = 1'b0;
    #3;
    for (int m = 0; m < 2; m++) begin
      nvec++;
      if (kw[m] !== 1'b0 || ko[m] !== 8'h00 || ks[m] !== 1'b0 || ov[m] !== 2'b00) begin
        nerr++;
        $display("FAIL reset_state m%0d got wen=%b out=%h src=%b ovf=%b want all zero",
                 m, kw[m], ko[m], ks[m], ov[m]);
      end
    end
    do_reset();
    // valid held high across release must not be captured
    for (int i = 0; i < 6; i++) cyc(2'b11, 8'hAA, 8'hBB, 1'b1, 1'b0);
    nvec++;
    if (got0.size() != 0 || got1.size() != 0) begin
      nerr++;
      $display("FAIL reset_held_dv got %0d/%0d dispatches want 0/0", got0.size(), got1.size());
    end
  endtask

  task automatic test_two_ch();
    do_reset();
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(2'b11, 8'h1C, 8'h32, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(2'b00, 8'h00, 8'h00, (i % 4 == 3), 1'b0);
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    nvec++;
    if (got1.size() != 2 || got1[0] !== 9'h01C || got1[1] !== 9'h132) begin
      nerr++;
      $display("FAIL two_ch_rr got n=%0d %h %h want n=2 01c 132", got1.size(), got1[0], got1[1]);
    end
  endtask

  task automatic test_held_valid();
    do_reset();
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(2'b01, 8'h55, 8'h00, (i == 4 || i == 9 || i == 14), 1'b0);
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    nvec++;
    if (got1.size() != 1 || got1[0] !== 9'h055) begin
      nerr++;
      $display("FAIL held_valid got n=%0d first=%h want n=1 055", got1.size(), got1[0]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(2'b01, 8'h10 + 8'(k), 8'h00, 1'b0, 1'b0);
      cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    for (int m = 0; m < 2; m++) begin
      nvec++;
      if (ov[m] !== 2'b01) begin
        nerr++;
        $display("FAIL ovf_set m%0d got %b want 01", m, ov[m]);
      end
    end
    for (int i = 0; i < 12; i++) cyc(2'b00, 8'h00, 8'h00, (i % 2 == 0), 1'b0);
    nvec++;
    if (got1.size() != 4 || got1[0] !== 9'h010 || got1[1] !== 9'h011 ||
        got1[2] !== 9'h012 || got1[3] !== 9'h013) begin
      nerr++;
      $display("FAIL ovf_order got n=%0d %h %h %h %h want 010 011 012 013",
               got1.size(), got1[0], got1[1], got1[2], got1[3]);
    end
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    nvec++;
    if (ov[0] !== 2'b00 || ov[1] !== 2'b00) begin
      nerr++;
      $display("FAIL ovf_clear got %b/%b want 00/00", ov[0], ov[1]);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(2'b11, 8'h21, 8'h41, 1'b0, 1'b0);
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(2'b11, 8'h22, 8'h42, 1'b0, 1'b0);
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(2'b00, 8'h00, 8'h00, (i % 2 == 0), 1'b0);
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    nvec++;
    if (got0.size() != 4 || got0[0] !== 9'h021 || got0[1] !== 9'h022 ||
        got0[2] !== 9'h141 || got0[3] !== 9'h142) begin
      nerr++;
      $display("FAIL prio_order got n=%0d %h %h %h %h want 021 022 141 142",
               got0.size(), got0[0], got0[1], got0[2], got0[3]);
    end
    nvec++;
    if (got1.size() != 4 || got1[0] !== 9'h021 || got1[1] !== 9'h141 ||
        got1[2] !== 9'h022 || got1[3] !== 9'h142) begin
      nerr++;
      $display("FAIL rr_order got n=%0d %h %h %h %h want 021 141 022 142",
               got1.size(), got1[0], got1[1], got1[2], got1[3]);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(2'b01, 8'h60 + 8'(k), 8'h00, 1'b0, 1'b0);
      cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    cyc(2'b01, 8'h64, 8'h00, 1'b1, 1'b0);
    nvec++;
    if (ov[0] !== 2'b00 || ov[1] !== 2'b00) begin
      nerr++;
      $display("FAIL full_push_pop_ovf got %b/%b want 00/00", ov[0], ov[1]);
    end
    for (int i = 0; i < 12; i++) cyc(2'b00, 8'h00, 8'h00, (i % 2 == 0), 1'b0);
    nvec++;
    if (got1.size() != 5 || got1[0] !== 9'h060 || got1[3] !== 9'h063 || got1[4] !== 9'h064) begin
      nerr++;
      $display("FAIL full_push_pop_drain got n=%0d %h..%h %h want n=5 060..063 064",
               got1.size(), got1[0], got1[3], got1[4]);
    end
  endtask

  task automatic test_latency();
    do_reset();
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(2'b01, 8'h77, 8'h00, 1'b1, 1'b0);   // push into empty with tick: no pop
    nvec++;
    if (kw[1] !== 1'b0) begin
      nerr++;
      $display("FAIL lat_same_cycle got wen=%b want 0", kw[1]);
    end
    cyc(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    nvec++;
    if (kw[1] !== 1'b1 || ko[1] !== 8'h77 || ks[1] !== 1'b0) begin
      nerr++;
      $display("FAIL lat_min got wen=%b out=%h src=%b want 1 77 0", kw[1], ko[1], ks[1]);
    end
    cyc(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);   // tick with all empty
    nvec++;
    if (kw[1] !== 1'b0 || ko[1] !== 8'h77) begin
      nerr++;
      $display("FAIL lat_empty_tick got wen=%b out=%h want 0 77 (held)", kw[1], ko[1]);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(2'b01, 8'h90 + 8'(k), 8'h00, 1'b0, 1'b0);
      cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    cyc(2'b01, 8'h93, 8'h00, 1'b1, 1'b0);
    nvec++;
    if (kw[1] !== 1'b1 || ko[1] !== 8'h90) begin
      nerr++;
      $display("FAIL midop_pre got wen=%b out=%h want 1 90", kw[1], ko[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      nvec++;
      if (kw[m] !== 1'b0 || ko[m] !== 8'h00 || ks[m] !== 1'b0 || ov[m] !== 2'b00) begin
        nerr++;
        $display("FAIL midop_async m%0d got wen=%b out=%h src=%b ovf=%b want zeros",
                 m, kw[m], ko[m], ks[m], ov[m]);
      end
    end
    do_reset();
    for (int i = 0; i < 8; i++) cyc(2'b01, 8'h99, 8'h00, 1'b1, 1'b0);
    nvec++;
    if (got0.size() != 0 || got1.size() != 0) begin
      nerr++;
      $display("FAIL midop_after got %0d/%0d dispatches want 0/0", got0.size(), got1.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      cyc(2'($urandom), 8'($urandom), 8'($urandom),
          ($urandom_range(2) == 0), ($urandom_range(15) == 0));
      for (int m = 0; m < 2; m++) begin
        nvec++;
        if (kw[m] !== ewen[m]) begin
          nerr++;
          $display("FAIL rnd_wen m%0d cyc%0d got %b want %b", m, n, kw[m], ewen[m]);
        end
        nvec++;
        if (ko[m] !== eout[m] || ks[m] !== esrc[m]) begin
          nerr++;
          $display("FAIL rnd_key m%0d cyc%0d got %h/%b want %h/%b", m, n, ko[m], ks[m], eout[m], esrc[m]);
        end
        nvec++;
        if (ov[m] !== movf[m]) begin
          nerr++;
          $display("FAIL rnd_ovf m%0d cyc%0d got %b want %b", m, n, ov[m], movf[m]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_two_ch();
    test_held_valid();
    test_overflow();
    test_priority();
    test_full_push_pop();
    test_latency();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0d vectors", nvec);
    $fatal(1);
  end
endmodule
